// File: rtl/audio_pkg.sv
// Shared constants and types for the mono PDM audio output path.
package audio_pkg;

    localparam int unsigned AUDIO_DATA_W = 16;
    localparam int unsigned PDM_CLK_DIV  = 100;

    typedef enum logic {
        IDLE,
        SHIFT
    } pdm_state_e;

    // Counter width for a terminal count of n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pdm_bit_tick.sv
// Clock-enable generator: one-cycle tick every CLK_DIV clocks, held at zero while cleared.
module pdm_bit_tick
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = PDM_CLK_DIV
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear_i || div_cnt_q == LAST_CNT) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    assign tick_o = !clear_i && (div_cnt_q == LAST_CNT);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/pdm_serializer.sv
// Serializes parallel audio words MSB first onto the PDM pin, one bit per CLK_DIV clocks,
// reloading back-to-back and pulsing done_o as each frame completes.
module pdm_serializer
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W  = AUDIO_DATA_W,
    parameter int unsigned CLK_DIV = PDM_CLK_DIV
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              done_o,
    output logic              pdm_audio_o,
    output logic              pdm_sdaudio_o
);

    localparam int unsigned BIT_W = cnt_width(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    pdm_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              done_q, done_d;
    logic              tick;
    logic              tick_clear;

    // Dropping enable clears the divider on the same edge the FSM returns to IDLE.
    assign tick_clear = (state_q == IDLE) || !enable_i;

    pdm_bit_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_tick (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .clear_i   (tick_clear),
        .tick_o    (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d   = SHIFT;
                    shreg_d   = data_i;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (!enable_i) begin
                    state_d   = IDLE;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                end else if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        shreg_d   = data_i;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    assign done_o        = done_q;
    assign pdm_audio_o   = (state_q == SHIFT) && shreg_q[DATA_W-1];
    assign pdm_sdaudio_o = (state_q == SHIFT);

endmodule

// File: tb/tb_pdm_serializer.sv
// Self-checking bench for pdm_serializer: frame-position model plus directed literal checks.
module tb_pdm_serializer;

    localparam int DATA_W  = 16;
    localparam int CLK_DIV = 100;
    localparam int FRAME   = DATA_W * CLK_DIV;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b1;
    logic [DATA_W-1:0] data = 16'h0001;
    logic              done;
    logic              pdm_audio;
    logic              pdm_sdaudio;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    pdm_serializer #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clock_i       (clk),
        .reset_n_i     (rst_n),
        .enable_i      (enable),
        .data_i        (data),
        .done_o        (done),
        .pdm_audio_o   (pdm_audio),
        .pdm_sdaudio_o (pdm_sdaudio)
    );

    always #5 clk = ~clk;

    // Model: running flag, word of the current frame and clock position inside it.
    logic              m_run  = 1'b0;
    logic              m_done = 1'b0;
    logic [DATA_W-1:0] m_word = '0;
    int                m_pos  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_word <= '0;
            m_pos  <= 0;
        end else if (!m_run) begin
            m_done <= 1'b0;
            if (enable) begin
                m_run  <= 1'b1;
                m_word <= data;
                m_pos  <= 0;
            end
        end else if (!enable) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_pos  <= 0;
        end else if (m_pos == FRAME - 1) begin
            m_pos  <= 0;
            m_word <= data;
            m_done <= 1'b1;
        end else begin
            m_pos  <= m_pos + 1;
            m_done <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic int slot = DATA_W - 1 - m_pos / CLK_DIV;
            automatic logic exp_audio = m_run && m_word[slot];
            check("model_audio", int'(pdm_audio), int'(exp_audio));
            check("model_sdaudio", int'(pdm_sdaudio), int'(m_run));
            check("model_done", int'(done), int'(m_done));
        end
    end

    task automatic measure(input int n, output int highs, output int dones,
                           output int sd_low, output int first_high);
        highs = 0;
        dones = 0;
        sd_low = 0;
        first_high = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (pdm_audio) begin
                highs++;
                if (first_high < 0) first_high = i;
            end
            if (done) dones++;
            if (!pdm_sdaudio) sd_low++;
        end
    endtask

    initial begin
        int h, d, s, f;

        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;

        // Reset held with enable high: everything stays quiet.
        measure(10, h, d, s, f);
        check("rst_highs", h, 0);
        check("rst_dones", d, 0);
        check("rst_sd_low", s, 10);
        rst_n = 1'b1;

        // Word 0x0001: k=0 is the first clock after the load edge.
        @(negedge clk);
        check("start_sd", int'(pdm_sdaudio), 1);
        check("start_audio", int'(pdm_audio), 0);
        measure(FRAME, h, d, s, f);
        check("w0001_highs", h, 100);
        check("w0001_first_high", f, 1500);
        check("w0001_dones", d, 1);
        check("w0001_done_at_frame_end", int'(done), 1);
        check("w0001_next_msb", int'(pdm_audio), 0);

        // Change data 800 clocks into the frame; current frame keeps 0x0001.
        repeat (800) @(negedge clk);
        data = 16'h0014;
        measure(800, h, d, s, f);
        check("midchange_highs", h, 100);
        check("midchange_dones", d, 1);

        // Frame of 0x0014: slots 11 and 13 high.
        measure(FRAME, h, d, s, f);
        check("w0014_highs", h, 200);
        check("w0014_first_high", f, 1100);
        check("w0014_dones", d, 1);

        // Frame still 0x0014 (loaded before the change), then all-zero word.
        data = 16'h0000;
        measure(FRAME, h, d, s, f);
        check("w0014b_highs", h, 200);
        measure(FRAME, h, d, s, f);
        check("w0000_highs", h, 0);
        check("w0000_dones", d, 1);
        check("w0000_sd_low", s, 0);

        // Abort 900 clocks into the frame.
        repeat (900) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_audio", int'(pdm_audio), 0);
        check("abort_sd", int'(pdm_sdaudio), 0);
        check("abort_done", int'(done), 0);
        measure(1700, h, d, s, f);
        check("idle_dones", d, 0);
        check("idle_sd_low", s, 1700);

        // Restart with 0xFFFF: a full frame of ones from the restart.
        data = 16'hFFFF;
        enable = 1'b1;
        measure(FRAME, h, d, s, f);
        check("wffff_highs", h, FRAME);
        check("wffff_first_high", f, 1);
        check("wffff_dones", d, 0);
        @(negedge clk);
        check("wffff_done", int'(done), 1);
        check("wffff_reload_audio", int'(pdm_audio), 1);

        // Asynchronous reset mid-frame.
        repeat (500) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_audio", int'(pdm_audio), 0);
        check("async_rst_sd", int'(pdm_sdaudio), 0);
        check("async_rst_done", int'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        measure(200, h, d, s, f);
        check("post_rst_highs", h, 200);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
